seq0247_checker: RTL
====================

Name: seq0247_checker

Overview:
Receive-side checker for the 0-2-4-7 3-bit sequence produced by the sequence generator. It acquires lock on the incoming symbol stream and flywheels through isolated errors. It reports lock status, per-error and per-period pulses, and saturating error and period counters. It sits downstream of the generator, or of any link carrying its output, as a self-checking monitor.

Parameters:
LOCK_CNT, 4, consecutive correct symbols (seed symbol included) needed to declare lock; must be >=1
UNLOCK_ERRS, 2, consecutive mismatches in lock needed to drop lock; must be >=1
CNT_W, 8, width of err_count and frame_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  q_in is sampled only when 1
q_in  in  3  received symbol
clr_cnt  in  1  synchronous clear of err_count and frame_count
locked  out  1  1 while in LOCK or FLYWHEEL
err  out  1  one-cycle pulse per mismatch counted in LOCK or FLYWHEEL
frame  out  1  one-cycle pulse when a matched 7 completes a period in LOCK or FLYWHEEL
err_count  out  CNT_W  saturating mismatch counter
frame_count  out  CNT_W  saturating period counter

Behaviour:
- Reset (asynchronous, active-high): state=HUNT; exp=0, good_cnt=0, bad_cnt=0; all outputs 0.
- Legal symbols: 0,2,4,7. Successor: next(0)=2, next(2)=4, next(4)=7, next(7)=0. Codes 1,3,5,6 are illegal and never match.
- A sample is accepted only on a clock edge with in_valid=1. With in_valid=0, state, exp and counters hold, and err and frame are 0.
- All outputs are registered, and update on the edge that accepts the sample (visible the following cycle).
- HUNT:
  - Legal symbol s: exp<=next(s), good_cnt<=1, go to SYNC. If LOCK_CNT==1, go directly to LOCK.
  - Illegal symbol: stay in HUNT.
  - No err pulses in HUNT.
- SYNC (match means q_in==exp):
  - Match: good_cnt++ and exp<=next(exp). When good_cnt reaches LOCK_CNT, go to LOCK.
  - Legal mismatch s: re-seed with exp<=next(s), good_cnt<=1, stay in SYNC.
  - Illegal symbol: go to HUNT, good_cnt<=0.
  - No err pulses in SYNC.
- LOCK:
  - Match: stay in LOCK.
  - Mismatch: err=1, err_count++, bad_cnt<=1. Go to FLYWHEEL, or to HUNT if UNLOCK_ERRS==1.
- FLYWHEEL:
  - Match: bad_cnt<=0, go to LOCK.
  - Mismatch: err=1, err_count++, bad_cnt++. When bad_cnt reaches UNLOCK_ERRS, go to HUNT.
- In LOCK and FLYWHEEL, exp<=next(exp) on every accepted sample, match or not.
- frame: pulses when current state is LOCK or FLYWHEEL, q_in==7 and it matches; frame_count++ on the same edge.
- locked=1 exactly when the registered state is LOCK or FLYWHEEL. It drops on the edge that enters HUNT.
- Counters saturate at 2^CNT_W-1 and never wrap. If clr_cnt and an increment occur on the same edge, the clear wins (result 0). clr_cnt does not affect state or lock.
- Reset asserted mid-lock: immediate return to reset values; reacquisition requires LOCK_CNT new correct symbols.

Decomposition:
- Package seq0247_pkg:
  - state enum {HUNT, SYNC, LOCK, FLYWHEEL}
  - symbol constants SYM0=3'd0, SYM2=3'd2, SYM4=3'd4, SYM7=3'd7
  - function next_sym(s) plus a legal flag
- Sub-module seq0247_succ: combinational successor and legality decode, instanced once for q_in and once for exp.
- FSM and counters live in seq0247_checker.

Test Plan:
1. Reset, then valid stream 0,2,4,7 (LOCK_CNT=4) -> locked=1 after the 7 is accepted. Continue 0,2,4,7 -> single frame pulse on that 7; frame_count=1, err_count=0.
2. Locked, send 0,5,4,7 -> one err pulse on the 5; err_count=1; locked stays 1; state returns to LOCK on the 4; frame pulses on the 7.
3. Locked, send 0,3,6 (UNLOCK_ERRS=2) -> err pulses on the 3 and the 6; err_count=2; locked=0 after the 6; then 0,2,4,7 relocks.
4. Locked, in_valid toggles 1,0,0,1 over symbols 2,x,x,4 -> no err; exp held across gaps; locked stays 1.
5. CNT_W=8, force 300 locked mismatch/recover pairs -> err_count sticks at 255. Assert clr_cnt together with an err -> err_count=0.
6. Locked, assert rst for 1 cycle mid-stream -> locked=0 and both counters 0 immediately; then 2,4,7,0 relocks after the 0.

Source files
------------

// File: rtl/seq0247_pkg.sv
// Shared types and symbol helpers for the 0-2-4-7 sequence checker.
package seq0247_pkg;

  typedef enum logic [1:0] {HUNT, SYNC, LOCK, FLYWHEEL} state_t;

  localparam logic [2:0] SYM0 = 3'd0;
  localparam logic [2:0] SYM2 = 3'd2;
  localparam logic [2:0] SYM4 = 3'd4;
  localparam logic [2:0] SYM7 = 3'd7;

  function automatic logic sym_legal(input logic [2:0] s);
    return (s == SYM0) || (s == SYM2) || (s == SYM4) || (s == SYM7);
  endfunction

  // Illegal codes map to SYM0; callers gate on sym_legal before using the result.
  function automatic logic [2:0] next_sym(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      SYM0:    n = SYM2;
      SYM2:    n = SYM4;
      SYM4:    n = SYM7;
      default: n = SYM0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq0247_succ.sv
// Combinational successor and legality decode of one 3-bit symbol.
module seq0247_succ
  import seq0247_pkg::*;
(
  input  logic [2:0] sym,
  output logic [2:0] nxt,
  output logic       legal
);

  always_comb begin
    nxt   = next_sym(sym);
    legal = sym_legal(sym);
  end

endmodule

// File: rtl/seq0247_checker.sv
// Receive-side lock/flywheel checker for the 0-2-4-7 symbol stream with
// saturating error and period counters.
module seq0247_checker
  import seq0247_pkg::*;
#(
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_ERRS = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       q_in,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic             frame,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] frame_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t        state;
  logic [2:0]    exp;
  logic [GW-1:0] good_cnt;
  logic [BW-1:0] bad_cnt;

  logic [2:0]    q_nxt, exp_nxt;
  logic          q_legal, exp_legal;
  logic          match, active, err_hit, frame_hit;
  logic [GW-1:0] good_inc;
  logic [BW-1:0] bad_inc;

  seq0247_succ u_succ_q   (.sym(q_in), .nxt(q_nxt),   .legal(q_legal));
  seq0247_succ u_succ_exp (.sym(exp),  .nxt(exp_nxt), .legal(exp_legal));

  always_comb begin
    match     = exp_legal && (q_in == exp);
    active    = (state == LOCK) || (state == FLYWHEEL);
    err_hit   = in_valid && active && !match;
    frame_hit = in_valid && active && match && (q_in == SYM7);
    good_inc  = good_cnt + GW'(1);
    bad_inc   = bad_cnt + BW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      exp         <= SYM0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
      frame       <= 1'b0;
      err_count   <= '0;
      frame_count <= '0;
    end else begin
      err   <= err_hit;
      frame <= frame_hit;

      // Clear has priority over a same-edge increment.
      if (clr_cnt)
        err_count <= '0;
      else if (err_hit && err_count != CNT_MAX)
        err_count <= err_count + CNT_W'(1);

      if (clr_cnt)
        frame_count <= '0;
      else if (frame_hit && frame_count != CNT_MAX)
        frame_count <= frame_count + CNT_W'(1);

      if (in_valid) begin
        case (state)
          HUNT: begin
            if (q_legal) begin
              exp      <= q_nxt;
              good_cnt <= GW'(1);
              if (LOCK_CNT == 1) begin
                state   <= LOCK;
                locked  <= 1'b1;
                bad_cnt <= '0;
              end else begin
                state <= SYNC;
              end
            end
          end
          SYNC: begin
            if (match) begin
              exp      <= exp_nxt;
              good_cnt <= good_inc;
              if (good_inc == GW'(LOCK_CNT)) begin
                state   <= LOCK;
                locked  <= 1'b1;
                bad_cnt <= '0;
              end
            end else if (q_legal) begin
              exp      <= q_nxt;
              good_cnt <= GW'(1);
            end else begin
              state    <= HUNT;
              good_cnt <= '0;
            end
          end
          LOCK: begin
            exp <= exp_nxt;
            if (!match) begin
              bad_cnt <= BW'(1);
              if (UNLOCK_ERRS == 1) begin
                state    <= HUNT;
                locked   <= 1'b0;
                good_cnt <= '0;
              end else begin
                state <= FLYWHEEL;
              end
            end
          end
          FLYWHEEL: begin
            exp <= exp_nxt;
            if (match) begin
              bad_cnt <= '0;
              state   <= LOCK;
            end else begin
              bad_cnt <= bad_inc;
              if (bad_inc == BW'(UNLOCK_ERRS)) begin
                state    <= HUNT;
                locked   <= 1'b0;
                good_cnt <= '0;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
